// File: rtl/aes_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Purpose  : Control FSM that steps an iterative AES datapath through its rounds.
// Revision : 1.0
// ============================================================================
module aes_round_sequencer #(
    parameter int CLK_PER_ROUND = 4,
    localparam int PW = (CLK_PER_ROUND > 1) ? $clog2(CLK_PER_ROUND) : 1
) (
    input  logic          clk,
    input  logic          kill,
    input  logic          in_en,
    input  logic [1:0]    key_len,
    input  logic          dec,
    input  logic          irq_clr,
    output logic          start,
    output logic          in_ready,
    output logic          busy,
    output logic [3:0]    round_idx,
    output logic [PW-1:0] round_phase,
    output logic          key_ready,
    output logic          en_mixcol,
    output logic          dec_mode,
    output logic          out_en,
    output logic          in_en_collision_irq,
    output logic          cfg_err
);

    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_PER_ROUND - 1);
    localparam logic [1:0]    KEY_LEN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    nr_q, nr_d;
    logic          dec_q, dec_d;
    logic          coll_q, coll_d;
    logic          cfg_q, cfg_d;
    logic          ready_w;
    logic          accept_w;

    assign ready_w  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept_w = in_en && ready_w && (key_len != KEY_LEN_RSVD);

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state_q <= S_IDLE;
            round_q <= '0;
            phase_q <= '0;
            nr_q    <= '0;
            dec_q   <= 1'b0;
            coll_q  <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            phase_q <= phase_d;
            nr_q    <= nr_d;
            dec_q   <= dec_d;
            coll_q  <= coll_d;
            cfg_q   <= cfg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        phase_d = phase_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        coll_d  = coll_q;
        cfg_d   = cfg_q;

        // A set event in the same cycle as irq_clr must win, so clear first.
        if (irq_clr) begin
            coll_d = 1'b0;
            cfg_d  = 1'b0;
        end
        if (in_en && !ready_w) begin
            coll_d = 1'b1;
        end
        if (in_en && (key_len == KEY_LEN_RSVD)) begin
            cfg_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                round_d = '0;
                phase_d = '0;
                state_d = S_IDLE;
                if (accept_w) begin
                    state_d = S_INIT;
                    // Nr = 10 + 2*key_len for the three legal encodings.
                    nr_d    = 4'd10 + {1'b0, key_len, 1'b0};
                    dec_d   = dec;
                end
            end
            S_INIT: begin
                state_d = S_ROUND;
                round_d = 4'd1;
                phase_d = '0;
            end
            S_ROUND: begin
                if (phase_q == PHASE_LAST) begin
                    phase_d = '0;
                    if (round_q == nr_q) begin
                        state_d = S_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start               = (state_q == S_INIT);
        in_ready            = ready_w;
        busy                = (state_q == S_INIT) || (state_q == S_ROUND);
        key_ready           = (state_q == S_INIT) ||
                              ((state_q == S_ROUND) && (phase_q == '0));
        en_mixcol           = (state_q == S_ROUND) && (round_q == nr_q);
        out_en              = (state_q == S_DONE);
        round_idx           = round_q;
        round_phase         = phase_q;
        dec_mode            = dec_q;
        in_en_collision_irq = coll_q;
        cfg_err             = cfg_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Two sequencer instances (4 and 2 clocks per round) share one stimulus stream and
// are compared every cycle against a model that derives outputs from elapsed cycles.
module tb_aes_round_sequencer;

    localparam int CPR_A = 4;
    localparam int CPR_B = 2;

    logic       clk = 1'b0;
    logic       kill, in_en, dec, irq_clr;
    logic [1:0] key_len;

    logic       start_a, in_ready_a, busy_a, key_ready_a, en_mixcol_a, dec_mode_a;
    logic       out_en_a, coll_a, cfg_a;
    logic [3:0] round_a;
    logic [1:0] phase_a;
    logic       start_b, in_ready_b, busy_b, key_ready_b, en_mixcol_b, dec_mode_b;
    logic       out_en_b, coll_b, cfg_b;
    logic [3:0] round_b;
    logic [0:0] phase_b;

    logic [16:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_cpr [2] = '{CPR_A, CPR_B};
    bit m_act [2];
    int m_t   [2];
    int m_nr  [2];
    bit m_dec [2];
    bit m_coll[2];
    bit m_cfg [2];

    always #5 clk = ~clk;

    aes_round_sequencer #(.CLK_PER_ROUND(CPR_A)) u_dut_a (
        .clk(clk), .kill(kill), .in_en(in_en), .key_len(key_len), .dec(dec),
        .irq_clr(irq_clr), .start(start_a), .in_ready(in_ready_a), .busy(busy_a),
        .round_idx(round_a), .round_phase(phase_a), .key_ready(key_ready_a),
        .en_mixcol(en_mixcol_a), .dec_mode(dec_mode_a), .out_en(out_en_a),
        .in_en_collision_irq(coll_a), .cfg_err(cfg_a)
    );

    aes_round_sequencer #(.CLK_PER_ROUND(CPR_B)) u_dut_b (
        .clk(clk), .kill(kill), .in_en(in_en), .key_len(key_len), .dec(dec),
        .irq_clr(irq_clr), .start(start_b), .in_ready(in_ready_b), .busy(busy_b),
        .round_idx(round_b), .round_phase(phase_b), .key_ready(key_ready_b),
        .en_mixcol(en_mixcol_b), .dec_mode(dec_mode_b), .out_en(out_en_b),
        .in_en_collision_irq(coll_b), .cfg_err(cfg_b)
    );

    // Bit map: 16 start, 15 in_ready, 14 busy, 13 key_ready, 12 en_mixcol,
    // 11 dec_mode, 10 out_en, 9 collision, 8 cfg_err, 7:4 round, 3:0 phase.
    assign obs_a = {start_a, in_ready_a, busy_a, key_ready_a, en_mixcol_a, dec_mode_a,
                    out_en_a, coll_a, cfg_a, round_a, 2'b00, phase_a};
    assign obs_b = {start_b, in_ready_b, busy_b, key_ready_b, en_mixcol_b, dec_mode_b,
                    out_en_b, coll_b, cfg_b, round_b, 3'b000, phase_b};

    function automatic logic [16:0] expect_vec(input int i);
        int   e, k, d, r, ph;
        logic st, rdy, bz, kr, mc, oe;
        st = 1'b0; rdy = 1'b1; bz = 1'b0; kr = 1'b0; mc = 1'b0; oe = 1'b0;
        r = 0; ph = 0;
        if (m_act[i]) begin
            e = cyc - m_t[i];
            d = 2 + m_nr[i] * m_cpr[i];
            if (e == 1) begin
                st = 1'b1; kr = 1'b1; bz = 1'b1; rdy = 1'b0;
            end else if (e >= 2 && e < d) begin
                k   = e - 2;
                r   = k / m_cpr[i] + 1;
                ph  = k % m_cpr[i];
                kr  = (ph == 0);
                mc  = (r == m_nr[i]);
                bz  = 1'b1;
                rdy = 1'b0;
            end else if (e == d) begin
                oe = 1'b1;
                r  = m_nr[i];
            end
        end
        return {st, rdy, bz, kr, mc, m_dec[i], oe, m_coll[i], m_cfg[i], 4'(r), 4'(ph)};
    endfunction

    initial forever begin
        logic [16:0] exp_v, got_v;
        logic        rdy_now;
        int          d;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (kill) begin
                m_act[i] = 1'b0; m_dec[i] = 1'b0; m_coll[i] = 1'b0; m_cfg[i] = 1'b0;
            end
            exp_v = expect_vec(i);
            got_v = (i == 0) ? obs_a : obs_b;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_cmp inst%0d cyc=%0d got=%h want=%h", i, cyc, got_v, exp_v);
            end
            if (!kill) begin
                rdy_now = exp_v[15];
                if (irq_clr) begin
                    m_coll[i] = 1'b0; m_cfg[i] = 1'b0;
                end
                if (in_en && !rdy_now) m_coll[i] = 1'b1;
                if (in_en && key_len == 2'b11) m_cfg[i] = 1'b1;
                if (m_act[i]) begin
                    d = 2 + m_nr[i] * m_cpr[i];
                    if (cyc - m_t[i] >= d) m_act[i] = 1'b0;
                end
                if (in_en && rdy_now && key_len != 2'b11) begin
                    m_act[i] = 1'b1;
                    m_t[i]   = cyc;
                    m_nr[i]  = 10 + 2 * int'(key_len);
                    m_dec[i] = dec;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic run_block(input string nm, input int inst, input logic [1:0] kl,
                             input logic d, input int lat_w, input int kr_w,
                             input int mc_lo_w, input int mc_hi_w);
        int          lat, kr, mc_lo, mc_hi, st_at;
        logic [16:0] v;
        lat = -1; kr = 0; mc_lo = -1; mc_hi = -1; st_at = -1;
        v = '0;
        in_en = 1'b1; key_len = kl; dec = d;
        tick();
        in_en = 1'b0; key_len = 2'($urandom); dec = 1'($urandom);
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(negedge clk);
            v = (inst == 0) ? obs_a : obs_b;
            if (v[16] && st_at < 0) st_at = n;
            if (v[13]) kr++;
            if (v[12]) begin
                if (mc_lo < 0) mc_lo = n;
                mc_hi = n;
            end
            if (v[10]) lat = n;
        end
        check({nm, "_start_at"}, st_at, 1);
        check({nm, "_latency"}, lat, lat_w);
        check({nm, "_key_ready_pulses"}, kr, kr_w);
        check({nm, "_mixcol_first"}, mc_lo, mc_lo_w);
        check({nm, "_mixcol_last"}, mc_hi, mc_hi_w);
        check({nm, "_dec_mode"}, int'(v[11]), int'(d));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int oe_cnt;
        kill = 1'b1; in_en = 1'b0; dec = 1'b0; irq_clr = 1'b0; key_len = 2'b00;
        idle(3);
        check("reset_outputs_a", int'(obs_a), 32'h8000);
        check("reset_outputs_b", int'(obs_b), 32'h8000);
        kill = 1'b0;
        tick();

        run_block("aes128_c4", 0, 2'b00, 1'b0, 42, 11, 38, 41);
        idle(80);
        run_block("aes256_dec_c2", 1, 2'b10, 1'b1, 30, 15, 28, 29);
        idle(80);

        // Back-to-back: second request lands in the out_en cycle.
        in_en = 1'b1; key_len = 2'b00; dec = 1'b0; tick(); in_en = 1'b0;
        idle(41);
        check("b2b_out_en", int'(obs_a[10]), 1);
        in_en = 1'b1; key_len = 2'b01; tick(); in_en = 1'b0;
        check("b2b_start", int'(obs_a[16]), 1);
        check("b2b_no_collision", int'(obs_a[9]), 0);
        idle(80);

        // Collision mid-block, then clear.
        in_en = 1'b1; key_len = 2'b00; tick(); in_en = 1'b0;
        idle(9);
        in_en = 1'b1; tick(); in_en = 1'b0;
        check("coll_set", int'(obs_a[9]), 1);
        check("coll_still_busy", int'(obs_a[14]), 1);
        idle(31);
        check("coll_out_en_on_time", int'(obs_a[10]), 1);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("coll_cleared", int'(obs_a[9]), 0);
        idle(60);

        // Reserved key length.
        in_en = 1'b1; key_len = 2'b11; tick(); in_en = 1'b0; key_len = 2'b00;
        check("cfg_err_set", int'(obs_a[8]), 1);
        check("cfg_no_busy", int'(obs_a[14]), 0);
        check("cfg_no_start", int'(obs_a[16]), 0);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        check("cfg_err_cleared", int'(obs_a[8]), 0);

        // Abort mid-block.
        in_en = 1'b1; key_len = 2'b10; tick(); in_en = 1'b0;
        idle(19);
        kill = 1'b1;
        #1;
        check("abort_outputs", int'(obs_a), 32'h8000);
        tick();
        kill = 1'b0;
        oe_cnt = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (obs_a[10]) oe_cnt++;
        end
        check("abort_no_out_en", oe_cnt, 0);
        run_block("after_abort", 0, 2'b00, 1'b0, 42, 11, 38, 41);

        // Randomized traffic, covered by the per-cycle model comparison.
        for (int k = 0; k < 800; k++) begin
            kill    = ($urandom_range(0, 299) == 0);
            in_en   = !kill && ($urandom_range(0, 7) == 0);
            key_len = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            dec     = 1'($urandom);
            irq_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        kill = 1'b0; in_en = 1'b0; irq_clr = 1'b0;
        idle(80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter CLK_PER_ROUND, default 4, giving the clocks per cipher round; legal values are 1..16.
REQ-002 SHALL have derived localparam PW = max(1, clog2(CLK_PER_ROUND)), the width of the phase counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port kill, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_en, input, 1 bit: single-cycle request to start one block.
REQ-006 SHALL have port key_len, input, 2 bits: 00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = reserved. Sampled with in_en.
REQ-007 SHALL have port dec, input, 1 bit: 1 selects decrypt. Sampled with in_en.
REQ-008 SHALL have port irq_clr, input, 1 bit: clears the sticky error flags.
REQ-009 SHALL have port start, output, 1 bit: one-cycle strobe that loads the datapath and applies the round-0 AddRoundKey.
REQ-010 SHALL have port in_ready, output, 1 bit: in_en will be accepted this cycle.
REQ-011 SHALL have port busy, output, 1 bit: a block is in flight.
REQ-012 SHALL have port round_idx, output, 4 bits: current round number, 0..Nr.
REQ-013 SHALL have port round_phase, output, PW bits: clock index within the current round.
REQ-014 SHALL have port key_ready, output, 1 bit: one-cycle request to the key expander for the round key of round_idx.
REQ-015 SHALL have port en_mixcol, output, 1 bit: high throughout the final round; MixColumns is bypassed while it is high.
REQ-016 SHALL have port dec_mode, output, 1 bit: dec as latched at acceptance.
REQ-017 SHALL have port out_en, output, 1 bit: one-cycle strobe marking the result as valid.
REQ-018 SHALL have port in_en_collision_irq, output, 1 bit: sticky flag, set when in_en arrives while not ready.
REQ-019 SHALL have port cfg_err, output, 1 bit: sticky flag, set when in_en arrives with key_len = 11.

Function
REQ-020 SHALL implement an FSM with states IDLE, INIT, ROUND and DONE.
REQ-021 SHALL drive in_ready = 1 in IDLE and DONE, and 0 otherwise.
REQ-022 SHALL accept a request in cycle T when in_en = 1, in_ready = 1 and key_len != 11. On acceptance it latches Nr and dec_mode and moves to INIT.
REQ-023 SHALL, in INIT (cycle T+1), assert start = 1 and key_ready = 1, drive round_idx = 0, and move to ROUND with round_idx = 1 and round_phase = 0.
REQ-024 SHALL, in ROUND, increment round_phase each cycle. At CLK_PER_ROUND-1 it wraps to 0 and round_idx increments. When round_idx = Nr and the phase wrap occurs, the FSM moves to DONE.
REQ-025 SHALL assert key_ready for exactly one cycle at round_phase = 0 of every round 1..Nr, giving Nr+1 pulses per block.
REQ-026 SHALL hold en_mixcol = 1 for all cycles where round_idx = Nr in ROUND, and 0 elsewhere.
REQ-027 SHALL, in DONE, assert out_en = 1 for one cycle with busy = 0. The FSM then goes to INIT if a request is accepted in that cycle, otherwise to IDLE.
REQ-028 SHALL use the following latency rule: out_en = 1 at cycle T + 2 + Nr*CLK_PER_ROUND. For CLK_PER_ROUND = 4 this is 42, 50 or 58 cycles for AES-128, AES-192 and AES-256.
REQ-029 SHALL support back-to-back blocks, with one accepted every Nr*CLK_PER_ROUND + 2 cycles.
REQ-030 SHALL hold busy = 1 in INIT and ROUND, and 0 in IDLE and DONE.
REQ-031 SHALL ignore in_en when in_ready = 0 and set in_en_collision_irq; the running block is unaffected.
REQ-032 SHALL ignore in_en with key_len = 11, set cfg_err and keep the state unchanged.
REQ-033 SHALL clear both sticky flags on irq_clr = 1. If a set event and irq_clr occur in the same cycle, the set wins.
REQ-034 SHALL leave Nr and dec_mode unaffected by changes on key_len or dec after acceptance.
REQ-035 SHALL, when CLK_PER_ROUND = 1, leave round_phase constant at 0 and advance the round every cycle.
REQ-036 SHALL hold round_idx = 0 and round_phase = 0 in IDLE, and hold round_idx at Nr in DONE.

Reset
REQ-037 SHALL, while kill = 1, asynchronously force state = IDLE and all counters, latches and outputs to 0, except in_ready, which is 1.
REQ-038 SHALL treat a kill mid-block as an abort: no out_en is produced, and the first edge after kill deasserts leaves the block in IDLE, ready.

Verification
REQ-039 SHALL cover the AES-128 case with CLK_PER_ROUND = 4: in_en at T with key_len = 00 gives start at T+1, 11 key_ready pulses, en_mixcol high over T+38..T+41, and out_en at T+42.
REQ-040 SHALL cover AES-256 decrypt with CLK_PER_ROUND = 2: dec = 1 and key_len = 10 give dec_mode = 1, 15 key_ready pulses, and out_en at T+30.
REQ-041 SHALL cover back-to-back operation: in_en in the out_en cycle gives the next start one cycle later with no collision flag.
REQ-042 SHALL cover collision: in_en at T+10 mid-block sets in_en_collision_irq and leaves out_en at T+42. A later irq_clr clears the flag.
REQ-043 SHALL cover the reserved key length: in_en with key_len = 11 sets cfg_err, keeps busy = 0 and gives no start.
REQ-044 SHALL cover abort: kill pulsed at T+20 drives all outputs to 0, no out_en ever occurs, and a new in_en afterwards completes normally.
